oc_button: RTL and testbench

OC_BUTTON -- requirements
Module: oc_button

---
 rtl/oc_button.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_oc_button.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_button.sv
// oc_button: debounced push-button / switch block with a CSR interface.
//
// Each raw input is synchronized, optionally inverted and debounced against a
// shared millisecond-scale prescaler tick. Presses are counted (saturating),
// and a sticky long-press flag is raised once a button has been held for a
// programmable number of ticks.
//
// Ports (oc_button):
//   clock       - sole clock
//   reset       - synchronous active-high reset
//   csr         - CSR request (read/write, word address, write data)
//   csrFb       - CSR response (ready pulse, error, read data)
//   buttonIn    - raw asynchronous button/switch pins
//   buttonOut   - debounced logical level (after invert)
//   buttonEvent - one-cycle pulse on each debounced press
//
// CSR map (word addresses):
//   0   : RO  [7:0] ButtonCount, [31:16] CsrIdButton
//   1   : RW  [19:0] prescaler terminal count
//   2+i : RW  [4:0] debounce ticks, [5] invert, [13:8] long-press/64, [15] clear
//         RO  [16] level, [17] longPress, [31:24] pressCount
//
// The file also carries the small oclib pieces this block depends on.

package oclib_pkg;

  localparam logic [15:0] CsrIdButton = 16'h0014;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_fb_s;

endpackage

// oclib_module_reset: optional reset synchronizer followed by an optional
// pipeline. Ports: clock, reset (raw), resetSync (conditioned reset).
module oclib_module_reset #(
  parameter int SyncCycles    = 3,
  parameter bit ResetSync     = 1'b0,
  parameter int ResetPipeline = 0
) (
  input  logic clock,
  input  logic reset,
  output logic resetSync
);

  logic synced;

  if (ResetSync) begin : gSync
    logic [SyncCycles-1:0] chain;
    always_ff @(posedge clock) chain <= (chain << 1) | SyncCycles'(reset);
    assign synced = chain[SyncCycles-1];
  end else begin : gNoSync
    assign synced = reset;
  end

  if (ResetPipeline > 0) begin : gPipe
    logic [ResetPipeline-1:0] pipe;
    always_ff @(posedge clock) pipe <= (pipe << 1) | ResetPipeline'(synced);
    assign resetSync = pipe[ResetPipeline-1];
  end else begin : gNoPipe
    assign resetSync = synced;
  end

endmodule

// oclib_csr_array: NumCsr 32-bit registers. Bits set in CsrRwBits are stored
// and writable; all other bits read back from csrRo. Every request gets a
// one-cycle ready response; out-of-range addresses return error.
// Ports: clock, reset, csr, csrFb, csrRw (stored values), csrRo (live values).
module oclib_csr_array #(
  parameter int                       NumCsr      = 1,
  parameter logic [NumCsr-1:0][31:0]  CsrRwBits   = '0,
  parameter logic [NumCsr-1:0][31:0]  CsrInitBits = '0,
  parameter type                      CsrType     = oclib_pkg::csr_32_s,
  parameter type                      CsrFbType   = oclib_pkg::csr_32_fb_s
) (
  input  logic                      clock,
  input  logic                      reset,
  input  CsrType                    csr,
  output CsrFbType                  csrFb,
  output logic [NumCsr-1:0][31:0]   csrRw,
  input  logic [NumCsr-1:0][31:0]   csrRo
);

  localparam int AddrBits = (NumCsr > 1) ? $clog2(NumCsr) : 1;

  logic                hit;
  logic [AddrBits-1:0] index;
  logic [31:0]         readValue;

  assign hit   = csr.address < 32'(NumCsr);
  assign index = csr.address[AddrBits-1:0];

  always_comb begin
    readValue = '0;
    if (hit) readValue = csrRw[index] | (csrRo[index] & ~CsrRwBits[index]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csrRw <= CsrInitBits & CsrRwBits;
      csrFb <= '0;
    end else begin
      csrFb <= '0;
      if (csr.read || csr.write) begin
        csrFb.ready <= 1'b1;
        csrFb.error <= !hit;
        if (csr.read) csrFb.rdata <= readValue;
      end
      if (csr.write && hit) csrRw[index] <= csr.wdata & CsrRwBits[index];
    end
  end

endmodule

module oc_button #(
  parameter int  ClockHz         = 100_000_000,
  parameter int  ButtonCount     = 1,
  localparam int ButtonCountSafe = (ButtonCount > 1) ? ButtonCount : 1,
  parameter type CsrType         = oclib_pkg::csr_32_s,
  parameter type CsrFbType       = oclib_pkg::csr_32_fb_s,
  parameter type CsrProtocol     = oclib_pkg::csr_32_s,
  parameter int  SyncCycles      = 3,
  parameter bit  ResetSync       = 1'b0,
  parameter int  ResetPipeline   = 0,
  parameter int  InputSyncCycles = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  CsrType                     csr,
  output CsrFbType                   csrFb,
  input  logic [ButtonCountSafe-1:0] buttonIn,
  output logic [ButtonCountSafe-1:0] buttonOut,
  output logic [ButtonCountSafe-1:0] buttonEvent
);

  localparam int          NumCsr = 2 + ButtonCount;
  localparam logic [19:0] TcInit = 20'((ClockHz / 1000) - 1);

  // Builds either the writable-bit masks or the reset values for the map.
  function automatic logic [NumCsr-1:0][31:0] makeBits(input bit init);
    logic [NumCsr-1:0][31:0] bits;
    bits = '0;
    bits[1] = init ? {12'h000, TcInit} : 32'h000F_FFFF;
    for (int i = 2; i < NumCsr; i++) bits[i] = init ? 32'h0 : 32'h0000_BF3F;
    return bits;
  endfunction

  localparam logic [NumCsr-1:0][31:0] RwBits   = makeBits(1'b0);
  localparam logic [NumCsr-1:0][31:0] InitBits = makeBits(1'b1);

  logic                    resetSync;
  CsrProtocol              csrProto;
  logic [NumCsr-1:0][31:0] csrRw;
  logic [NumCsr-1:0][31:0] csrRo;
  logic                    unusedCsr;
  logic [19:0]             tc;
  logic [19:0]             prescaleCount;
  logic                    tick;

  oclib_module_reset #(
    .SyncCycles   (SyncCycles),
    .ResetSync    (ResetSync),
    .ResetPipeline(ResetPipeline)
  ) uReset (
    .clock    (clock),
    .reset    (reset),
    .resetSync(resetSync)
  );

  assign csrProto = csr;

  oclib_csr_array #(
    .NumCsr     (NumCsr),
    .CsrRwBits  (RwBits),
    .CsrInitBits(InitBits),
    .CsrType    (CsrProtocol),
    .CsrFbType  (CsrFbType)
  ) uCsr (
    .clock(clock),
    .reset(resetSync),
    .csr  (csrProto),
    .csrFb(csrFb),
    .csrRw(csrRw),
    .csrRo(csrRo)
  );

  assign unusedCsr = ^csrRw;
  assign csrRo[0]  = {oclib_pkg::CsrIdButton, 8'h00, 8'(ButtonCount)};
  assign csrRo[1]  = '0;

  // Comparing with >= (not ==) means a TC written below the running count
  // ticks on the next cycle instead of waiting for a 20-bit wrap.
  assign tc   = csrRw[1][19:0];
  assign tick = prescaleCount >= tc;

  always_ff @(posedge clock) begin
    if (resetSync) prescaleCount <= '0;
    else           prescaleCount <= tick ? 20'd0 : prescaleCount + 20'd1;
  end

  for (genvar i = 0; i < ButtonCountSafe; i++) begin : gButton
    logic [4:0]                 debounceTicks;
    logic                       invert;
    logic [5:0]                 longTicks;
    logic                       clear;
    logic [InputSyncCycles-1:0] syncChain;
    logic                       sample;
    logic                       level;
    logic                       toggle;
    logic                       press;
    logic [4:0]                 debounceCount;
    logic [15:0]                holdCount;
    logic [7:0]                 pressCount;
    logic                       longPress;
    logic                       eventPulse;

    if (i < ButtonCount) begin : gCfg
      assign debounceTicks = csrRw[2+i][4:0];
      assign invert        = csrRw[2+i][5];
      assign longTicks     = csrRw[2+i][13:8];
      assign clear         = csrRw[2+i][15];
      assign csrRo[2+i]    = {pressCount, 6'h00, longPress, level, 16'h0000};
    end else begin : gNoCfg
      assign debounceTicks = '0;
      assign invert        = 1'b0;
      assign longTicks     = '0;
      assign clear         = 1'b0;
    end

    // Invert is applied after the synchronizer, so flipping it looks like an
    // ordinary input change and goes through the same debounce.
    assign sample = syncChain[InputSyncCycles-1] ^ invert;
    assign toggle = (sample != level) && tick && (debounceCount >= debounceTicks);
    assign press  = toggle && !level;

    always_ff @(posedge clock) begin
      if (resetSync) begin
        syncChain     <= '0;
        level         <= 1'b0;
        debounceCount <= '0;
        holdCount     <= '0;
        pressCount    <= '0;
        longPress     <= 1'b0;
        eventPulse    <= 1'b0;
      end else begin
        syncChain <= (syncChain << 1) | InputSyncCycles'(buttonIn[i]);

        if (sample == level) begin
          debounceCount <= '0;
        end else if (tick) begin
          if (toggle) begin
            level         <= !level;
            debounceCount <= '0;
          end else begin
            debounceCount <= debounceCount + 5'd1;
          end
        end

        eventPulse <= press;

        if (!level)                             holdCount <= '0;
        else if (tick && holdCount != 16'hFFFF) holdCount <= holdCount + 16'd1;

        // Clear has priority so software can hold the statistics at zero.
        if (clear)                              pressCount <= '0;
        else if (press && pressCount != 8'hFF)  pressCount <= pressCount + 8'd1;

        if (clear) longPress <= 1'b0;
        else if (longTicks != 6'd0 && holdCount >= {4'h0, longTicks, 6'h00}) longPress <= 1'b1;
      end
    end

    assign buttonOut[i]   = level;
    assign buttonEvent[i] = eventPulse;
  end

endmodule

// File: tb/tb_oc_button.sv
// tb_oc_button: randomized self-checking bench for oc_button.
//
// A behavioural model follows the button rules tick by tick; CSR reads push
// their expected response into a queue that a separate monitor drains when
// csrFb.ready is seen. The monitor also checks buttonOut/buttonEvent every
// cycle against the model.

module tb_oc_button;

  localparam int ClockHz         = 10_000;
  localparam int ButtonCount     = 2;
  localparam int InputSyncCycles = 2;
  localparam int NumCsr          = 2 + ButtonCount;

  logic                    clock = 1'b0;
  logic                    reset;
  oclib_pkg::csr_32_s      csr;
  oclib_pkg::csr_32_fb_s   csrFb;
  logic [ButtonCount-1:0]  buttonIn;
  logic [ButtonCount-1:0]  buttonOut;
  logic [ButtonCount-1:0]  buttonEvent;

  int compared   = 0;
  int mismatched = 0;
  int dutEvents  = 0;
  bit finalCheck = 1'b0;
  bit finalDone  = 1'b0;

  oc_button #(
    .ClockHz        (ClockHz),
    .ButtonCount    (ButtonCount),
    .InputSyncCycles(InputSyncCycles)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .csr        (csr),
    .csrFb      (csrFb),
    .buttonIn   (buttonIn),
    .buttonOut  (buttonOut),
    .buttonEvent(buttonEvent)
  );

  always #5 clock = ~clock;

  // Reference model state
  int                     mPrescale = 0;
  logic [31:0]            mReg [NumCsr];
  logic [ButtonCount-1:0] inHist [$];
  bit                     mLevel [ButtonCount];
  bit                     mEvent [ButtonCount];
  bit                     mLong [ButtonCount];
  int                     mMismatchTicks [ButtonCount];
  int                     mHold [ButtonCount];
  int                     mPresses [ButtonCount];
  int                     modelEvents = 0;
  logic [32:0]            expectQ [$];

  function automatic logic [31:0] rwMask(input logic [31:0] addr);
    if (addr == 1) return 32'h000F_FFFF;
    if (addr >= 2) return 32'h0000_BF3F;
    return 32'h0;
  endfunction

  function automatic logic [32:0] readModel(input logic [31:0] addr);
    logic [31:0] ro;
    if (addr >= NumCsr) return {1'b1, 32'h0};
    if (addr == 0) return {1'b0, oclib_pkg::CsrIdButton, 8'h00, 8'(ButtonCount)};
    if (addr == 1) return {1'b0, mReg[1]};
    ro = {8'(mPresses[addr-2]), 6'h00, mLong[addr-2], mLevel[addr-2], 16'h0000};
    return {1'b0, mReg[addr] | ro};
  endfunction

  task automatic modelReset();
    mPrescale = 0;
    for (int a = 0; a < NumCsr; a++) mReg[a] = 32'h0;
    mReg[1] = 32'((ClockHz / 1000) - 1);
    inHist.delete();
    for (int k = 0; k < InputSyncCycles; k++) inHist.push_back('0);
    for (int b = 0; b < ButtonCount; b++) begin
      mLevel[b] = 1'b0;
      mEvent[b] = 1'b0;
      mLong[b] = 1'b0;
      mMismatchTicks[b] = 0;
      mHold[b] = 0;
      mPresses[b] = 0;
    end
  endtask

  // A level flips once the input has disagreed with it for debounce+1 ticks
  // without ever agreeing in between.
  task automatic stepButton(input int b, input bit raw, input bit tick);
    logic [31:0] cfg;
    int deb;
    int longTicks;
    bit clr;
    bit wanted;
    bit flip;
    bit reachLong;
    cfg       = mReg[2+b];
    deb       = int'(cfg[4:0]);
    longTicks = int'(cfg[13:8]);
    clr       = cfg[15];
    wanted    = raw ^ cfg[5];
    flip      = 1'b0;
    reachLong = (longTicks != 0) && (mHold[b] >= longTicks * 64);
    if (wanted == mLevel[b]) begin
      mMismatchTicks[b] = 0;
    end else if (tick) begin
      mMismatchTicks[b]++;
      if (mMismatchTicks[b] > deb) begin
        flip = 1'b1;
        mMismatchTicks[b] = 0;
      end
    end
    if (!mLevel[b]) mHold[b] = 0;
    else if (tick && mHold[b] < 65535) mHold[b]++;
    mEvent[b] = flip && !mLevel[b];
    if (mEvent[b]) modelEvents++;
    if (clr) begin
      mPresses[b] = 0;
      mLong[b] = 1'b0;
    end else begin
      if (mEvent[b] && mPresses[b] < 255) mPresses[b]++;
      if (reachLong) mLong[b] = 1'b1;
    end
    mLevel[b] = mLevel[b] ^ flip;
  endtask

  initial modelReset();

  always @(posedge clock) begin : model
    logic [ButtonCount-1:0] synced;
    bit tick;
    if (reset) begin
      modelReset();
    end else begin
      if (csr.read)       expectQ.push_back(readModel(csr.address));
      else if (csr.write) expectQ.push_back({csr.address >= NumCsr, 32'h0});
      tick = mPrescale >= int'(mReg[1][19:0]);
      mPrescale = tick ? 0 : mPrescale + 1;
      synced = inHist.pop_front();
      inHist.push_back(buttonIn);
      for (int b = 0; b < ButtonCount; b++) stepButton(b, synced[b], tick);
      if (csr.write && csr.address < NumCsr) mReg[csr.address] = csr.wdata & rwMask(csr.address);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clock) begin : monitor
    logic [ButtonCount-1:0] expOut;
    logic [ButtonCount-1:0] expEvt;
    logic [32:0]            expResp;
    for (int b = 0; b < ButtonCount; b++) begin
      expOut[b] = mLevel[b];
      expEvt[b] = mEvent[b];
    end
    checkOutput("buttonOut", 32'(buttonOut), 32'(expOut));
    checkOutput("buttonEvent", 32'(buttonEvent), 32'(expEvt));
    dutEvents += $countones(buttonEvent);
    if (csrFb.ready === 1'b1) begin
      checkOutput("csrResponseExpected", 32'(expectQ.size() != 0), 32'd1);
      if (expectQ.size() != 0) begin
        expResp = expectQ.pop_front();
        checkOutput("csrRdata", csrFb.rdata, expResp[31:0]);
        checkOutput("csrError", 32'(csrFb.error), 32'(expResp[32]));
      end
    end
    if (finalCheck && !finalDone) begin
      checkOutput("pendingResponses", 32'(expectQ.size()), 32'd0);
      checkOutput("eventTotal", 32'(dutEvents), 32'(modelEvents));
      finalDone = 1'b1;
    end
  end

  task automatic applyStimulus(input logic [ButtonCount-1:0] buttons, input int cycles);
    buttonIn = buttons;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic csrWrite(input int addr, input logic [31:0] data);
    csr.read    = 1'b0;
    csr.write   = 1'b1;
    csr.address = 32'(addr);
    csr.wdata   = data;
    @(negedge clock);
    csr = '0;
  endtask

  task automatic csrRead(input int addr);
    csr.read    = 1'b1;
    csr.write   = 1'b0;
    csr.address = 32'(addr);
    csr.wdata   = 32'h0;
    @(negedge clock);
    csr = '0;
  endtask

  task automatic pulseReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int choice;
    reset    = 1'b1;
    buttonIn = '0;
    csr      = '0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    $display("[TB] reset released, reading CSR map");

    for (int a = 0; a <= NumCsr; a++) csrRead(a);

    // Basic press with TC=9, debounce 3, then a 25-cycle glitch
    csrWrite(2, 32'h0000_0003);
    applyStimulus(2'b01, 80);
    csrRead(2);
    applyStimulus(2'b00, 80);
    applyStimulus(2'b01, 25);
    applyStimulus(2'b00, 60);
    csrRead(2);

    // Randomized traffic
    for (int seg = 0; seg < 60; seg++) begin
      choice = int'($urandom_range(0, 19));
      if (choice < 5)
        csrWrite(int'($urandom_range(2, 3)),
                 {16'h0000, 1'(choice == 0), 1'b0, 6'($urandom_range(0, 2)), 2'b00,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 4))});
      else if (choice < 8)  csrRead(int'($urandom_range(0, NumCsr)));
      else if (choice < 10) csrWrite(1, 32'($urandom_range(0, 12)));
      else if (choice == 10) pulseReset(int'($urandom_range(1, 3)));
      applyStimulus(2'($urandom), int'($urandom_range(1, 60)));
    end

    // Long press at TC=0 with threshold 2, then clear
    pulseReset(2);
    csrWrite(1, 32'h0);
    csrWrite(3, 32'h0000_0200);
    applyStimulus(2'b10, 140);
    csrRead(3);
    applyStimulus(2'b00, 20);
    csrRead(3);
    csrWrite(3, 32'h0000_8200);
    csrRead(3);
    csrWrite(3, 32'h0000_0200);
    csrRead(3);

    // Invert with the pin idle high, then a low press
    buttonIn = 2'b01;
    csrWrite(2, 32'h0000_0023);
    applyStimulus(2'b01, 20);
    csrRead(2);
    applyStimulus(2'b00, 12);
    applyStimulus(2'b01, 12);
    csrRead(2);

    // Press counter saturation
    csrWrite(2, 32'h0000_8000);
    csrWrite(2, 32'h0000_0000);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(2'b01, 4);
      applyStimulus(2'b00, 4);
    end
    csrRead(2);

    // Reset mid-debounce, then TC shrunk below the running count
    csrWrite(1, 32'd9);
    csrWrite(2, 32'h0000_0003);
    applyStimulus(2'b01, 20);
    pulseReset(2);
    applyStimulus(2'b01, 60);
    csrWrite(1, 32'd2000);
    applyStimulus(2'b00, 300);
    csrWrite(1, 32'd5);
    applyStimulus(2'b01, 40);
    csrRead(1);
    csrRead(2);

    repeat (3) @(negedge clock);
    finalCheck = 1'b1;
    for (int i = 0; i < 10 && !finalDone; i++) @(negedge clock);
    if (!finalDone) begin
      $display("[TB] FAIL finalCheck: monitor did not complete, got 0, expected 1");
      $fatal(1, "[TB] monitor stalled");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
